// File: rtl/fastica_pkg.sv
// fastica_pkg: shared fixed-point constants, FSM state type and saturation helper
package fastica_pkg;
  localparam int DATA_W = 32;
  localparam int ACC_W = DATA_W + 4;
  localparam int FRAC_BITS = 20;
  localparam logic signed [DATA_W-1:0] ONE = 32'sh0010_0000;
  typedef enum logic [1:0] {IDLE, MAC, CMP, DONE} conv_state_t;
  function automatic logic signed [DATA_W-1:0] sat_q(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] hi, lo;
    hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    return a > hi ? {1'b0, {(DATA_W-1){1'b1}}} : a < lo ? {1'b1, {(DATA_W-1){1'b0}}} : a[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/conv_check_5d_if.sv
// conv_check_5d_if: request/result bundle between the normaliser side and the convergence checker
interface conv_check_5d_if import fastica_pkg::*; #(
  parameter int DIMENSIONS = 5,
  parameter int DATA_WIDTH = DATA_W,
  parameter int ITER_WIDTH = 8
);
  logic [DIMENSIONS*DATA_WIDTH-1:0] w_in;
  logic start;
  logic clear;
  logic busy;
  logic done;
  logic converged;
  logic max_iter_hit;
  logic [DATA_WIDTH-1:0] dot_out;
  logic [ITER_WIDTH-1:0] iter_count;
  modport master(output w_in, start, clear, input busy, done, converged, max_iter_hit, dot_out, iter_count);
  modport slave(input w_in, start, clear, output busy, done, converged, max_iter_hit, dot_out, iter_count);
endinterface

// File: rtl/fx_mac.sv
// fx_mac: signed Q-format multiply, arithmetic rescale and wide accumulate with sync clear
module fx_mac import fastica_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W,
  parameter int FRAC_BITS = fastica_pkg::FRAC_BITS,
  parameter int ACC_WIDTH = ACC_W
) (
  input  logic clk,
  input  logic nreset,
  input  logic clr,
  input  logic en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] acc
);
  logic signed [2*DATA_WIDTH-1:0] prod;
  assign prod = a * b;
  // accumulate the rescaled product; clear has priority over enable
  always_ff @(posedge clk)
    if (!nreset || clr) acc <= '0;
    else if (en) acc <= acc + ACC_WIDTH'(prod >>> FRAC_BITS);
endmodule

// File: rtl/conv_check_5d.sv
// conv_check_5d: dot product of successive FastICA vectors and convergence/iteration tracking
module conv_check_5d import fastica_pkg::*; #(
  parameter int DIMENSIONS = 5,
  parameter int DATA_WIDTH = DATA_W,
  parameter int FRAC_BITS = fastica_pkg::FRAC_BITS,
  parameter logic [DATA_WIDTH-1:0] TOL = 'h400,
  parameter int MAX_ITER = 64,
  parameter int ITER_WIDTH = 8
) (
  input logic clk,
  input logic nreset,
  conv_check_5d_if.slave bus
);
  localparam int ACC_WIDTH = DATA_WIDTH + 4;
  localparam int IDXW = $clog2(DIMENSIONS);
  localparam logic [ACC_WIDTH-1:0] THRESH = (ACC_WIDTH'(1) << FRAC_BITS) - ACC_WIDTH'(TOL);
  conv_state_t state, state_n;
  logic [IDXW-1:0] idx;
  logic [DIMENSIONS*DATA_WIDTH-1:0] w_cur, w_prev;
  logic prev_valid, accept;
  logic signed [ACC_WIDTH-1:0] acc, acc_abs;
  logic [ITER_WIDTH-1:0] iter_n;
  assign accept = state == IDLE && bus.start && !bus.clear;
  assign acc_abs = acc < 0 ? -acc : acc;
  assign iter_n = bus.iter_count == ITER_WIDTH'(MAX_ITER) ? bus.iter_count : bus.iter_count + 1'b1;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  fx_mac #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk(clk),
    .nreset(nreset),
    .clr(accept),
    .en(state == MAC),
    .a(w_cur[idx*DATA_WIDTH +: DATA_WIDTH]),
    .b(w_prev[idx*DATA_WIDTH +: DATA_WIDTH]),
    .acc(acc)
  );
  // state register
  always_ff @(posedge clk)
    if (!nreset) state <= IDLE;
    else state <= state_n;
  // sequencing: clear aborts from anywhere, start only honoured when idle
  always_comb begin
    state_n = state;
    state_n = bus.clear ? IDLE :
              state == IDLE ? (bus.start ? MAC : IDLE) :
              state == MAC ? (idx == IDXW'(DIMENSIONS-1) ? CMP : MAC) :
              state == CMP ? DONE : IDLE;
  end
  // operand capture, element index and result registers updated in CMP
  always_ff @(posedge clk)
    if (!nreset) begin
      idx <= '0;
      w_cur <= '0;
      w_prev <= '0;
      prev_valid <= 1'b0;
      bus.dot_out <= '0;
      bus.converged <= 1'b0;
      bus.max_iter_hit <= 1'b0;
      bus.iter_count <= '0;
    end else if (bus.clear) begin
      prev_valid <= 1'b0;
      bus.converged <= 1'b0;
      bus.max_iter_hit <= 1'b0;
      bus.iter_count <= '0;
    end else begin
      if (accept) begin
        w_cur <= bus.w_in;
        idx <= '0;
      end
      if (state == MAC) idx <= idx + 1'b1;
      if (state == CMP) begin
        bus.dot_out <= prev_valid ? sat_q(acc) : '0;
        bus.converged <= prev_valid && $unsigned(acc_abs) >= THRESH;
        w_prev <= w_cur;
        prev_valid <= 1'b1;
        bus.iter_count <= iter_n;
        bus.max_iter_hit <= iter_n == ITER_WIDTH'(MAX_ITER);
      end
    end
endmodule

// File: tb/tb_conv_check_5d.sv
// tb_conv_check_5d: directed and randomised checks of conv_check_5d against an arithmetic model
module tb_conv_check_5d;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;
  conv_check_5d_if bus();
  conv_check_5d_if bus3();
  conv_check_5d dut(.clk(clk), .nreset(nreset), .bus(bus.slave));
  conv_check_5d #(.MAX_ITER(3)) dut3(.clk(clk), .nreset(nreset), .bus(bus3.slave));
  int tests = 0;
  int fails = 0;
  logic [159:0] prev = '0;
  bit pv = 0;
  int it = 0;
  logic [31:0] edot = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint dotm(input logic [159:0] a, input logic [159:0] b);
    longint s = 0;
    for (int i = 0; i < 5; i++)
      s += (longint'($signed(a[i*32 +: 32])) * longint'($signed(b[i*32 +: 32]))) >>> 20;
    return s;
  endfunction

  task automatic run(input string tag, input logic [159:0] v);
    int n;
    longint s, ab;
    bit ec;
    s = dotm(v, prev);
    ab = s < 0 ? -s : s;
    edot = !pv ? 32'h0 : s > 64'sh7fffffff ? 32'h7fffffff : s < -64'sh80000000 ? 32'h80000000 : s[31:0];
    ec = pv && ab >= (64'sd1 << 20) - 1024;
    it = it < 64 ? it + 1 : 64;
    bus.w_in = v;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, ".busy"}, bus.busy, 1);
    end while (!bus.done && n < 20);
    chk({tag, ".latency"}, n, 7);
    chk({tag, ".dot"}, bus.dot_out, edot);
    chk({tag, ".conv"}, bus.converged, ec);
    chk({tag, ".iter"}, bus.iter_count, it);
    chk({tag, ".hit"}, bus.max_iter_hit, it == 64);
    @(negedge clk);
    chk({tag, ".done_pulse"}, bus.done, 0);
    prev = v;
    pv = 1;
  endtask

  task automatic run3(input int k);
    int n;
    bus3.w_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    bus3.start = 1'b1;
    @(posedge clk);
    #1 bus3.start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus3.done && n < 20);
    chk("m3.latency", n, 7);
    chk("m3.iter", bus3.iter_count, k < 3 ? k : 3);
    chk("m3.hit", bus3.max_iter_hit, k >= 3);
    @(negedge clk);
  endtask

  initial begin
    logic [159:0] u, v;
    bit seen;
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] u, v;
    bit seen;
    u = 160'h0010_0000;
    bus.w_in = '0; bus.start = 0; bus.clear = 0;
    bus3.w_in = '0; bus3.start = 0; bus3.clear = 0;
    repeat (3) @(negedge clk);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.conv", bus.converged, 0);
    chk("rst.hit", bus.max_iter_hit, 0);
    chk("rst.dot", bus.dot_out, 0);
    chk("rst.iter", bus.iter_count, 0);
    nreset = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) run3(k);
    run("unit1", u);
    run("unit2", u);
    run("e1", {64'h0, 32'h0010_0000, 32'h0});
    run("e1neg", {64'h0, 32'hFFF0_0000, 32'h0});
    run("tol_pre1", u);
    run("tol_in", 160'h000F_FC00);
    run("tol_pre2", u);
    run("tol_out", 160'h000F_FBFF);
    run("sat_pos1", {5{32'h0400_0000}});
    run("sat_pos2", {5{32'h0400_0000}});
    run("sat_neg", {5{32'hFC00_0000}});
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 5; i++) begin
        if (r % 3 == 2) v[i*32 +: 32] = -prev[i*32 +: 32] + (int'($urandom_range(0, 600)) - 300);
        else v[i*32 +: 32] = int'($urandom_range(0, 2097152)) - 1048576;
      end
      run("rand", v);
    end
    bus.w_in = u;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    @(negedge clk);
    chk("clr.busy", bus.busy, 0);
    chk("clr.iter", bus.iter_count, 0);
    chk("clr.conv", bus.converged, 0);
    chk("clr.hit", bus.max_iter_hit, 0);
    chk("clr.dot_hold", bus.dot_out, edot);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("clr.no_done", seen, 0);
    pv = 0;
    it = 0;
    run("after_clr", u);
    bus.w_in = u;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    chk("mrst.busy", bus.busy, 0);
    chk("mrst.iter", bus.iter_count, 0);
    chk("mrst.dot", bus.dot_out, 0);
    chk("mrst.done", bus.done, 0);
    nreset = 1'b1;
    pv = 0;
    it = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("mrst.no_done", seen, 0);
    run("after_rst", u);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv_check_5d.md
# conv_check_5d

Convergence check for the 5-D FastICA fixed-point iteration. It sits directly downstream of `norm_5d` and consumes each normalized `W_out` vector. It computes the dot product of that vector with the vector from the previous iteration, using a single sequential multiply-accumulate. It reports whether |w_new·w_old| has reached 1 within a tolerance, and keeps the iteration count used by the top-level controller.

## Interface
Parameters:
- `DIMENSIONS`, 5, vector length.
- `DATA_WIDTH`, 32, element width, signed Q11.20.
- `FRAC_BITS`, 20, fractional bits, so 1.0 = 0x00100000.
- `TOL`, 32'h00000400, convergence tolerance (≈0.001) in the same Q format.
- `MAX_ITER`, 64, iteration limit.
- `ITER_WIDTH`, 8, width of `iter_count`.

Ports (all signals are on one clock, `clk`; `nreset` is synchronous and active-low):
- `clk`  in  1  clock.
- `nreset`  in  1  synchronous active-low reset.
- `w_in`  in  DIMENSIONS*DATA_WIDTH  normalized vector (element 0 in [31:0]); connects to `norm_5d.W_out`.
- `start`  in  1  one-cycle request; driven from `norm_5d.done`.
- `clear`  in  1  forget the previous vector and reset the iteration count (start of a new component).
- `busy`  out  1  high from the start-accept edge until `done`.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `converged`  out  1  |dot| ≥ ONE−TOL and a previous vector existed.
- `max_iter_hit`  out  1  `iter_count` == MAX_ITER.
- `dot_out`  out  DATA_WIDTH  signed dot product, saturated.
- `iter_count`  out  ITER_WIDTH  number of completed checks since the last clear or reset.

## Operation
- Reset: every output is 0. `prev_valid`, `w_prev`, the accumulator and the index are all 0. The FSM is in IDLE.
- FSM states: IDLE → MAC → CMP → DONE → IDLE.
- IDLE:
  - `start`=1 and `clear`=0: latch `w_in` into `w_cur`, clear the accumulator, set idx=0, go to MAC.
  - `start` outside IDLE is ignored.
- MAC (DIMENSIONS cycles), once per cycle:
  - acc += (w_cur[idx]·w_prev[idx]) >>> FRAC_BITS.
  - Product is signed 2·DATA_WIDTH bits; the shift is arithmetic (rounds toward −∞).
  - Accumulator is DATA_WIDTH+4 bits, so no internal overflow.
  - After idx = DIMENSIONS−1, go to CMP.
- CMP (1 cycle), updates these registers:
  - `dot_out` = acc saturated to [0x80000000, 0x7FFFFFFF], or 0 if !prev_valid.
  - `converged` = prev_valid && (|acc| ≥ (1<<FRAC_BITS) − TOL). |acc| is taken on the wide accumulator, so no abs overflow occurs.
  - `w_prev` ← `w_cur`; `prev_valid` ← 1.
  - `iter_count` ← iter_count+1, saturating at MAX_ITER.
  - `max_iter_hit` ← (new count == MAX_ITER).
- DONE: `done`=1 for this single cycle, then IDLE.
- `clear`:
  - Takes effect in any state: `prev_valid`, `iter_count`, `converged` and `max_iter_hit` go to 0.
  - If busy, abort to IDLE with no `done` pulse; `dot_out` is unchanged.
  - `clear` and `start` together in IDLE: `clear` wins and `start` is dropped.
- Sign: converged is insensitive to sign, so w and −w both count as converged.

## Timing
- `start` sampled at edge E:
  - `busy` is high from E to E+DIMENSIONS+2.
  - CMP at edge E+DIMENSIONS+1; `done` is high in the cycle after edge E+DIMENSIONS+1.
  - Latency is 7 cycles for DIMENSIONS=5.
- Back-to-back use: the next `start` is accepted in the cycle after `done` falls; the earliest is E+8.
- Outputs hold their values until the next CMP, `clear`, or reset.
- `nreset` low mid-operation: full reset on that edge; no `done` is issued.

## Structure
- Shared package `fastica_pkg`:
  - `FRAC_BITS` and `ONE` constants.
  - FSM state typedef `conv_state_t` (IDLE/MAC/CMP/DONE).
  - Saturation function `sat_q`.
- Sub-module `fx_mac`: signed multiply, arithmetic shift, and wide accumulate with a synchronous clear. It is reused later by the Gram-Schmidt decorrelation stage.

## Test plan
- After reset, w_in=(1,0,0,0,0) (w0=0x00100000), start → `done` after 7 cycles with `converged`=0, `dot_out`=0, `iter_count`=1.
- Same vector again → `dot_out`=0x00100000, `converged`=1, `iter_count`=2.
- w_in=(0,1,0,0,0), then w_in=(0,−1,0,0,0) → first check gives `dot_out`=0, `converged`=0; second gives `dot_out`=0xFFF00000, `converged`=1.
- Tolerance boundary, both checks after a prior w=(1,0,0,0,0):
  - w0 = 0x00100000−0x400 gives `converged`=1.
  - w0 = 0x00100000−0x401 gives `converged`=0.
- `MAX_ITER`=3, four starts → `iter_count` reads 1, 2, 3, 3; `max_iter_hit` is high from the third `done` on.
- `clear` asserted in the 3rd MAC cycle → no `done` pulse, `busy` drops on the next edge, `iter_count`=0. The next start gives `converged`=0 and `dot_out`=0.
